// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
package serial_adder_ctrl_pkg;

    localparam int DEF_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle of the serial adder: operands and start go in, result and status come out.
// Handshake: start is a request taken on any rising edge while idle or done; busy is high for the
// W cycles of the operation; done is a one-cycle strobe in the cycle sum/cout/ovf first show the new result.
interface serial_adder_ctrl_if #(
    parameter int W = 8
) ();
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_ctrl_fulladder.sv
// 1-bit full-adder cell shared by the serial datapath.
module fulladder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic co,
    output logic s
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell processes one operand bit per cycle, LSB first.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus,
    output state_t              dbg_state
);

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  sa;
    logic [W-1:0]  sb;
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic          c;
    logic          cmsb;
    logic          fa_s;
    logic          fa_co;
    logic          load;
    logic          last;

    fulladder u_fa (
        .x  (sa[0]),
        .y  (sb[0]),
        .ci (c),
        .co (fa_co),
        .s  (fa_s)
    );

    assign load = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;
    assign last = (cnt == CW'(W - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: state_nxt = bus.start ? ST_RUN : ST_IDLE;
            ST_RUN:           state_nxt = last ? ST_DONE : ST_RUN;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa       <= '0;
            sb       <= '0;
            acc      <= '0;
            cnt      <= '0;
            c        <= 1'b0;
            cmsb     <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else if (load) begin
            // Subtraction is a + ~b + 1, so the carry chain starts at 1.
            sa  <= bus.a;
            sb  <= bus.sub ? ~bus.b : bus.b;
            c   <= bus.sub ? 1'b1 : bus.cin;
            cnt <= '0;
            acc <= '0;
        end else if (state == ST_RUN) begin
            sa  <= {1'b0, sa[W-1:1]};
            sb  <= {1'b0, sb[W-1:1]};
            acc <= {fa_s, acc[W-1:1]};
            c   <= fa_co;
            cnt <= cnt + CW'(1);
            // Carry into the MSB, needed for signed overflow on the final bit.
            if (cnt == CW'(W - 2)) begin
                cmsb <= fa_co;
            end
            if (last) begin
                bus.sum  <= {fa_s, acc[W-1:1]};
                bus.cout <= fa_co;
                bus.ovf  <= fa_co ^ cmsb;
            end
        end
    end

    assign bus.busy  = (state == ST_RUN);
    assign bus.done  = (state == ST_DONE);
    assign dbg_state = state;

endmodule
